osc_keying_sequencer: RTL

Programmable on-off keying sequencer that sits between the UART receiver and the oscillator enable register bank in the singing transmitter. It consumes the 16-bit command words delivered by the UART interface and stores tone entries in a small program memory. It then plays them back as timed, mutually exclusive oscillator selections, so the antenna emits a sequence of tones without host involvement. Immediate `0xFF nn` select commands keep their existing meaning, so host software written for direct selection still works.

---
 rtl/osc_seq_pkg.sv | 23 ++
 rtl/osc_seq_tick_gen.sv | 25 ++
 rtl/osc_keying_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/osc_seq_pkg.sv
// Shared opcodes, entry layout and state encoding for the oscillator keying sequencer.
package osc_seq_pkg;

  localparam logic [7:0] OP_IMM   = 8'hFF;
  localparam logic [3:0] OP_ENQ   = 4'hC;
  localparam logic [7:0] OP_START = 8'hA0;
  localparam logic [7:0] OP_STOP  = 8'hA1;
  localparam logic [7:0] OP_CLEAR = 8'hA2;
  localparam int         NUM_OSC  = 8;

  typedef struct packed {
    logic       silent;
    logic [2:0] osc;
    logic [7:0] dur;
  } entry_t;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  function automatic logic [NUM_OSC-1:0] entry_en(entry_t e);
    entry_en = e.silent ? '0 : (NUM_OSC'(1) << e.osc);
  endfunction

endpackage

// File: rtl/osc_seq_tick_gen.sv
// Duration-tick prescaler: one-cycle tick every TICK_CYCLES enabled cycles, synchronous restart.
module osc_seq_tick_gen #(
  parameter int TICK_CYCLES = 12000
) (
  input  logic clk_12mhz_int,
  input  logic M_RESET_B,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW   = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
    if (!M_RESET_B)                              r_cnt <= '0;
    else if (!i_en || i_restart || r_cnt == LAST) r_cnt <= '0;
    else                                         r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/osc_keying_sequencer.sv
// On-off keying sequencer: decodes UART command words, stores tone entries, plays them back.
// Optional guard gap of one tick after every entry when SEQ_GUARD_GAP_EN is defined.
module osc_keying_sequencer
  import osc_seq_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TICK_CYCLES = 12000
) (
  input  logic                   clk_12mhz_int,
  input  logic                   M_RESET_B,
  input  logic [15:0]            cmd_data,
  input  logic                   cmd_valid,
  output logic [7:0]             osc_en,
  output logic                   seq_active,
  output logic                   seq_done,
  output logic [$clog2(DEPTH):0] prog_count,
  output logic                   prog_overflow,
  output logic [1:0]             o_dbg_state
);

  localparam int AW = $clog2(DEPTH);

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_repeats;
  logic [7:0]    r_dur_cnt;
  logic [AW:0]   r_prog_count;
  logic          r_overflow;
  logic [7:0]    r_osc_en;
  logic          r_seq_active;
  logic          r_seq_done;
  entry_t        r_mem [DEPTH];

  logic [7:0]    w_op, w_arg, w_imm_en, w_next_rep;
  logic          w_imm, w_enq, w_start_ok, w_stop, w_clear, w_full;
  logic          w_tick, w_entry_end, w_last, w_adv, w_finish, w_restart;
  logic [AW-1:0] w_next_idx;
  entry_t        w_cur;

  assign w_op       = cmd_data[15:8];
  assign w_arg      = cmd_data[7:0];
  assign w_imm      = cmd_valid && (w_op == OP_IMM);
  assign w_enq      = cmd_valid && (w_op[7:4] == OP_ENQ);
  assign w_stop     = cmd_valid && (w_op == OP_STOP);
  assign w_clear    = cmd_valid && (w_op == OP_CLEAR);
  assign w_start_ok = cmd_valid && (w_op == OP_START) && (r_state == IDLE) && (r_prog_count != '0);
  assign w_full     = (r_prog_count == (AW+1)'(DEPTH));
  assign w_imm_en   = (w_arg < 8'd8) ? (8'd1 << w_arg[2:0]) : 8'd0;

  // Combinational read of the current entry; dur==0 wraps to 255 so it lasts 256 ticks.
  assign w_cur       = r_mem[r_idx];
  assign w_entry_end = (r_state == PLAY) && w_tick && (r_dur_cnt == w_cur.dur - 8'd1);

  // End-of-entry decision uses the pre-write prog_count.
  assign w_last     = ({1'b0, r_idx} == r_prog_count - 1'b1);
  assign w_next_idx = w_last ? '0 : r_idx + 1'b1;
  assign w_finish   = w_last && (r_repeats == 8'd1);
  assign w_next_rep = (w_last && (r_repeats > 8'd1)) ? r_repeats - 8'd1 : r_repeats;

`ifdef SEQ_GUARD_GAP_EN
  assign w_adv = (r_state == GAP) && w_tick;
`else
  assign w_adv = w_entry_end;
`endif

  assign w_restart = w_start_ok | w_entry_end | w_adv;

  osc_seq_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk_12mhz_int (clk_12mhz_int),
    .M_RESET_B     (M_RESET_B),
    .i_en          (r_state != IDLE),
    .i_restart     (w_restart),
    .o_tick        (w_tick)
  );

  always_ff @(posedge clk_12mhz_int) begin
    if (w_enq && !w_full) r_mem[r_prog_count[AW-1:0]] <= entry_t'(cmd_data[11:0]);
  end

  always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
    if (!M_RESET_B) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_repeats    <= '0;
      r_dur_cnt    <= '0;
      r_prog_count <= '0;
      r_overflow   <= 1'b0;
      r_osc_en     <= '0;
      r_seq_active <= 1'b0;
      r_seq_done   <= 1'b0;
    end else begin
      r_seq_done <= 1'b0;
      if (w_imm) begin
        r_state      <= IDLE;
        r_seq_active <= 1'b0;
        r_osc_en     <= w_imm_en;
      end else if (w_stop || w_clear) begin
        r_state      <= IDLE;
        r_seq_active <= 1'b0;
        r_osc_en     <= '0;
      end else if (w_start_ok) begin
        r_state      <= PLAY;
        r_seq_active <= 1'b1;
        r_idx        <= '0;
        r_repeats    <= w_arg;
        r_dur_cnt    <= '0;
        r_osc_en     <= entry_en(r_mem[0]);
      end else if (w_adv) begin
        if (w_finish) begin
          r_state      <= IDLE;
          r_seq_active <= 1'b0;
          r_seq_done   <= 1'b1;
          r_osc_en     <= '0;
        end else begin
          r_state   <= PLAY;
          r_idx     <= w_next_idx;
          r_repeats <= w_next_rep;
          r_dur_cnt <= '0;
          r_osc_en  <= entry_en(r_mem[w_next_idx]);
        end
`ifdef SEQ_GUARD_GAP_EN
      end else if (w_entry_end) begin
        r_state   <= GAP;
        r_dur_cnt <= '0;
        r_osc_en  <= '0;
`endif
      end else if ((r_state == PLAY) && w_tick) begin
        r_dur_cnt <= r_dur_cnt + 8'd1;
      end

      if (w_clear) begin
        r_prog_count <= '0;
        r_overflow   <= 1'b0;
      end else if (w_enq) begin
        if (w_full) r_overflow   <= 1'b1;
        else        r_prog_count <= r_prog_count + 1'b1;
      end
    end
  end

  assign osc_en        = r_osc_en;
  assign seq_active    = r_seq_active;
  assign seq_done      = r_seq_done;
  assign prog_count    = r_prog_count;
  assign prog_overflow = r_overflow;
  assign o_dbg_state   = r_state;

endmodule
